ifft_seq: RTL and testbench



---
 rtl/ifft_seq.sv | 206 ++++++++++++++++++++
 tb/tb_ifft_seq.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_seq.sv
// Sequential radix-2 DIT inverse FFT.
// Serial load, one shared butterfly, serial unload.
module ifft_seq #(
  parameter int N  = 8,
  parameter int W  = 15,
  parameter int TW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [W:0]  in_re,
  input  logic signed [W:0]  in_im,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [W:0]  out_re,
  output logic signed [W:0]  out_im,
  output logic               out_last,
  output logic               busy
);

  localparam int LG = $clog2(N);
  localparam int AW = LG;
  localparam int KW = AW - 1;
  localparam int SW = (LG > 1) ? $clog2(LG) : 1;
  localparam int NH = N / 2;
  localparam int PW = TW + W + 1;
  localparam int W1 = W + 1;
  localparam int W2 = W + 2;
  localparam int W3 = W + 3;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0] cnt;
  logic [AW-1:0] bf;
  logic [AW-1:0] idx;
  logic [SW-1:0] stage;

  logic signed [W:0] mem_re [N];
  logic signed [W:0] mem_im [N];

  logic signed [TW-1:0] rom_re [NH];
  logic signed [TW-1:0] rom_im [NH];

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  // Conjugate twiddle exp(+j*2*pi*k/N), rounded and clamped to Q1.(TW-1)
  function automatic logic signed [TW-1:0] tw_val(input int k,
                                                  input bit sel_im);
    real a, v, s, lim;
    a   = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
    v   = sel_im ? $sin(a) : $cos(a);
    lim = 2.0 ** (TW - 1);
    s   = v * lim;
    s   = (s >= 0.0) ? s + 0.5 : s - 0.5;
    if (s > lim - 1.0) s = lim - 1.0;
    if (s < -lim) s = -lim;
    return TW'($rtoi(s));
  endfunction

  for (genvar g = 0; g < NH; g++) begin : g_rom
    assign rom_re[g] = tw_val(g, 1'b0);
    assign rom_im[g] = tw_val(g, 1'b1);
  end

  logic ld_fire;
  logic ul_fire;
  logic bf_wrap;
  logic last_bf;

  assign ld_fire = (state == LOAD) && in_valid;
  assign ul_fire = (state == UNLOAD) && out_ready;
  assign bf_wrap = (bf == AW'(NH - 1));
  assign last_bf = bf_wrap && (stage == SW'(LG - 1));

  logic [AW-1:0] half;
  logic [AW-1:0] jj;
  logic [AW-1:0] top;
  logic [AW-1:0] bot;
  logic [KW-1:0] kk;

  logic signed [TW-1:0] wr, wi;
  logic signed [W:0]    ar, ai, br, bi;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [W2-1:0] q_rr, q_ii, q_ri, q_ir;
  logic signed [W2-1:0] t_re, t_im;
  logic signed [W3-1:0] s_tre, s_tim, s_bre, s_bim;
  logic signed [W:0]    n_tre, n_tim, n_bre, n_bim;

  // Butterfly address generation and datapath for the current bf/stage
  always_comb begin
    half = AW'(1) << stage;
    jj   = bf & (half - AW'(1));
    top  = ((bf >> stage) << (int'(stage) + 1)) | jj;
    bot  = top | half;
    kk   = KW'(jj << (LG - 1 - int'(stage)));
    wr   = rom_re[kk];
    wi   = rom_im[kk];
    ar   = mem_re[top];
    ai   = mem_im[top];
    br   = mem_re[bot];
    bi   = mem_im[bot];
    p_rr = PW'(wr) * PW'(br);
    p_ii = PW'(wi) * PW'(bi);
    p_ri = PW'(wr) * PW'(bi);
    p_ir = PW'(wi) * PW'(br);
    q_rr = W2'(p_rr >>> (TW - 1));
    q_ii = W2'(p_ii >>> (TW - 1));
    q_ri = W2'(p_ri >>> (TW - 1));
    q_ir = W2'(p_ir >>> (TW - 1));
    t_re = q_rr - q_ii;
    t_im = q_ri + q_ir;
    s_tre = W3'(ar) + W3'(t_re);
    s_tim = W3'(ai) + W3'(t_im);
    s_bre = W3'(ar) - W3'(t_re);
    s_bim = W3'(ai) - W3'(t_im);
    n_tre = W1'(s_tre >>> 1);
    n_tim = W1'(s_tim >>> 1);
    n_bre = W1'(s_bre >>> 1);
    n_bim = W1'(s_bim >>> 1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD: begin
        if (in_valid && (cnt == AW'(N - 1))) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        if (last_bf) state_nxt = UNLOAD;
      end
      UNLOAD: begin
        if (out_ready && (idx == AW'(N - 1))) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Load counter, butterfly/stage counters and unload index
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      bf    <= '0;
      stage <= '0;
      idx   <= '0;
    end else begin
      if (ld_fire) begin
        cnt <= (cnt == AW'(N - 1)) ? '0 : cnt + AW'(1);
      end
      if (state == COMPUTE) begin
        if (bf_wrap) begin
          bf    <= '0;
          stage <= (stage == SW'(LG - 1)) ? '0 : stage + SW'(1);
        end else begin
          bf <= bf + AW'(1);
        end
      end
      if (ul_fire) begin
        idx <= (idx == AW'(N - 1)) ? '0 : idx + AW'(1);
      end
    end
  end

  // Sample memory: bit-reversed load writes, in-place butterfly writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ld_fire) begin
        mem_re[bitrev(cnt)] <= in_re;
        mem_im[bitrev(cnt)] <= in_im;
      end else if (state == COMPUTE) begin
        mem_re[top] <= n_tre;
        mem_im[top] <= n_tim;
        mem_re[bot] <= n_bre;
        mem_im[bot] <= n_bim;
      end
    end
  end

  // Handshake and output data decoded from state
  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == UNLOAD);
    busy      = (state != LOAD);
    out_last  = (state == UNLOAD) && (idx == AW'(N - 1));
    out_re    = (state == UNLOAD) ? mem_re[idx] : '0;
    out_im    = (state == UNLOAD) ? mem_im[idx] : '0;
  end

endmodule

// File: tb/tb_ifft_seq.sv
// Directed testbench for ifft_seq (N=8, W=15).
// Scenario tasks with inline checks and a final summary.
module tb_ifft_seq;

  localparam int N  = 8;
  localparam int W  = 15;
  localparam int TW = 16;

  localparam int SB_RE [N] = '{1000, 707, 0, -707, -1000, -707, 0, 707};
  localparam int SB_IM [N] = '{0, 707, 1000, 707, 0, -707, -1000, -707};

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [W:0] in_re;
  logic signed [W:0] in_im;
  logic              out_valid;
  logic              out_ready;
  logic signed [W:0] out_re;
  logic signed [W:0] out_im;
  logic              out_last;
  logic              busy;

  ifft_seq #(.N(N), .W(W), .TW(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [W:0] fr_re [N];
  logic signed [W:0] fr_im [N];
  logic signed [W:0] cap_re [N];
  logic signed [W:0] cap_im [N];
  logic              cap_last [N];
  logic signed [W:0] ub_re [N];
  logic signed [W:0] ub_im [N];
  int last_in_cyc;
  int first_val_cyc;

  task automatic set_frame(input logic signed [W:0] v, input int bin);
    for (int i = 0; i < N; i++) begin
      fr_re[i] = (i == bin) ? v : '0;
      fr_im[i] = '0;
    end
  endtask

  task automatic load_frame(input bit garbage, output bit to);
    int g;
    to = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_re = fr_re[k];
      in_im = fr_im[k];
      g = 0;
      while (!in_ready && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (!in_ready) to = 1'b1;
      @(posedge clk);
      #1;
      last_in_cyc = cyc;
    end
    @(negedge clk);
    if (garbage) begin
      in_valid = 1'b1;
      in_re = 16'sh5a5a;
      in_im = -16'sd1234;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic unload_frame(output bit to);
    int n;
    int g;
    n = 0;
    g = 0;
    first_val_cyc = -1;
    out_ready = 1'b1;
    while (n < N && g < 300) begin
      @(negedge clk);
      g++;
      if (out_valid) begin
        if (first_val_cyc < 0) first_val_cyc = cyc;
        cap_re[n] = out_re;
        cap_im[n] = out_im;
        cap_last[n] = out_last;
        n++;
      end
    end
    to = (n < N);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_in_ready: got %b expected 1", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_out_valid: got %b expected 0", out_valid);
    end
    n_cmp++;
    if (out_last !== 1'b0) begin
      n_err++;
      $display("FAIL rst_out_last: got %b expected 0", out_last);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_busy: got %b expected 0", busy);
    end
    n_cmp++;
    if (out_re !== 16'sd0 || out_im !== 16'sd0) begin
      n_err++;
      $display("FAIL rst_out_data: got %0d,%0d expected 0,0",
               out_re, out_im);
    end
    rst = 1'b0;
  endtask

  task automatic test_dc;
    bit to;
    set_frame(16'sd8000, 0);
    load_frame(1'b0, to);
    n_cmp++;
    if (to !== 1'b0) begin
      n_err++;
      $display("FAIL dc_load_timeout: got %b expected 0", to);
    end
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL dc_compute_flags: got busy=%b rdy=%b vld=%b expected 1 0 0",
               busy, in_ready, out_valid);
    end
    unload_frame(to);
    n_cmp++;
    if (to !== 1'b0) begin
      n_err++;
      $display("FAIL dc_unload_timeout: got %b expected 0", to);
    end
    n_cmp++;
    if (first_val_cyc - last_in_cyc < 12) begin
      n_err++;
      $display("FAIL dc_latency: got %0d cycles expected >= 12",
               first_val_cyc - last_in_cyc);
    end
    for (int n = 0; n < N; n++) begin
      n_cmp++;
      if (cap_re[n] !== 16'sd1000 || cap_im[n] !== 16'sd0) begin
        n_err++;
        $display("FAIL dc_x[%0d]: got %0d,%0d expected 1000,0",
                 n, cap_re[n], cap_im[n]);
      end
      n_cmp++;
      if (cap_last[n] !== (n == N - 1)) begin
        n_err++;
        $display("FAIL dc_last[%0d]: got %b expected %b",
                 n, cap_last[n], (n == N - 1));
      end
    end
  endtask

  task automatic test_single_bin;
    bit to;
    int dr;
    int di;
    set_frame(16'sd8000, 1);
    load_frame(1'b0, to);
    unload_frame(to);
    n_cmp++;
    if (to !== 1'b0) begin
      n_err++;
      $display("FAIL bin_timeout: got %b expected 0", to);
    end
    for (int n = 0; n < N; n++) begin
      ub_re[n] = cap_re[n];
      ub_im[n] = cap_im[n];
      dr = int'(cap_re[n]) - SB_RE[n];
      di = int'(cap_im[n]) - SB_IM[n];
      n_cmp++;
      if (dr > 2 || dr < -2 || di > 2 || di < -2) begin
        n_err++;
        $display("FAIL bin_x[%0d]: got %0d,%0d expected %0d,%0d +-2",
                 n, cap_re[n], cap_im[n], SB_RE[n], SB_IM[n]);
      end
    end
  endtask

  task automatic test_backpressure;
    bit to;
    int n;
    int g;
    int step;
    int dr;
    int di;
    bit held_v;
    logic signed [W:0] h_re;
    logic signed [W:0] h_im;
    logic h_last;
    set_frame(16'sd8000, 1);
    load_frame(1'b0, to);
    n = 0;
    g = 0;
    step = 0;
    held_v = 1'b0;
    h_re = '0;
    h_im = '0;
    h_last = 1'b0;
    out_ready = 1'b0;
    while (n < N && g < 400) begin
      @(negedge clk);
      g++;
      if (held_v) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_re !== h_re ||
            out_im !== h_im || out_last !== h_last) begin
          n_err++;
          $display("FAIL bp_hold[%0d]: got v=%b %0d,%0d l=%b expected 1 %0d,%0d l=%b",
                   n, out_valid, out_re, out_im, out_last, h_re, h_im, h_last);
        end
      end
      held_v = 1'b0;
      if (out_valid) begin
        out_ready = (step % 3 == 0);
        step++;
        if (out_ready) begin
          cap_re[n] = out_re;
          cap_im[n] = out_im;
          cap_last[n] = out_last;
          n++;
        end else begin
          held_v = 1'b1;
          h_re = out_re;
          h_im = out_im;
          h_last = out_last;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    n_cmp++;
    if (n != N) begin
      n_err++;
      $display("FAIL bp_count: got %0d expected %0d", n, N);
    end
    for (int i = 0; i < N; i++) begin
      dr = int'(cap_re[i]) - SB_RE[i];
      di = int'(cap_im[i]) - SB_IM[i];
      n_cmp++;
      if (dr > 2 || dr < -2 || di > 2 || di < -2 ||
          cap_re[i] !== ub_re[i] || cap_im[i] !== ub_im[i]) begin
        n_err++;
        $display("FAIL bp_x[%0d]: got %0d,%0d expected %0d,%0d (unstalled %0d,%0d)",
                 i, cap_re[i], cap_im[i], SB_RE[i], SB_IM[i], ub_re[i], ub_im[i]);
      end
      n_cmp++;
      if (cap_last[i] !== (i == N - 1)) begin
        n_err++;
        $display("FAIL bp_last[%0d]: got %b expected %b",
                 i, cap_last[i], (i == N - 1));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_end: got vld=%b rdy=%b expected 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    bit to;
    set_frame(16'sd8000, 0);
    load_frame(1'b1, to);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_ready_low: got %b expected 0", in_ready);
    end
    unload_frame(to);
    n_cmp++;
    if (to !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_a_timeout: got %b expected 0", to);
    end
    for (int n = 0; n < N; n++) begin
      n_cmp++;
      if (cap_re[n] !== 16'sd1000 || cap_im[n] !== 16'sd0) begin
        n_err++;
        $display("FAIL b2b_a_x[%0d]: got %0d,%0d expected 1000,0",
                 n, cap_re[n], cap_im[n]);
      end
    end
    set_frame(16'sd32767, 0);
    load_frame(1'b0, to);
    unload_frame(to);
    n_cmp++;
    if (to !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_b_timeout: got %b expected 0", to);
    end
    for (int n = 0; n < N; n++) begin
      n_cmp++;
      if (cap_re[n] !== 16'sd4095 || cap_im[n] !== 16'sd0) begin
        n_err++;
        $display("FAIL fullscale_x[%0d]: got %0d,%0d expected 4095,0",
                 n, cap_re[n], cap_im[n]);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit to;
    int n;
    int g;
    set_frame(16'sd8000, 0);
    load_frame(1'b0, to);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_compute: got rdy=%b vld=%b busy=%b expected 1 0 0",
               in_ready, out_valid, busy);
    end
    rst = 1'b0;
    set_frame(16'sd2000, 3);
    load_frame(1'b0, to);
    out_ready = 1'b1;
    n = 0;
    g = 0;
    while (n < 3 && g < 200) begin
      @(negedge clk);
      g++;
      if (out_valid) n++;
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_unload_pre: got vld=%b expected 1", out_valid);
    end
    rst = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_unload: got rdy=%b vld=%b busy=%b expected 1 0 0",
               in_ready, out_valid, busy);
    end
    rst = 1'b0;
    set_frame(16'sd8000, 0);
    load_frame(1'b0, to);
    unload_frame(to);
    n_cmp++;
    if (to !== 1'b0) begin
      n_err++;
      $display("FAIL rst_dc_timeout: got %b expected 0", to);
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (cap_re[i] !== 16'sd1000 || cap_im[i] !== 16'sd0) begin
        n_err++;
        $display("FAIL rst_dc_x[%0d]: got %0d,%0d expected 1000,0",
                 i, cap_re[i], cap_im[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dc();
    test_single_bin();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
